// File: rtl/pc_stack_unit_if.sv
// Command and status bundle for the program-counter / return-stack unit.
interface pc_stack_unit_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              flush_pc;
    logic              inc;
    logic              dec;
    logic              load;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] load_addr;
    logic              pc_out_en;
    logic [ADDR_W-1:0] pc_value;
    logic              stack_empty;
    logic              stack_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush_pc, inc, dec, load, call, ret, load_addr, pc_out_en,
        input  pc_value, stack_empty, stack_full, overflow, underflow
    );

    modport slave (
        input  flush_pc, inc, dec, load, call, ret, load_addr, pc_out_en,
        output pc_value, stack_empty, stack_full, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with step inc/dec, jump, and call/return via a LIFO
// return-address stack. Wrap or saturate arithmetic; tri-state bus copy.
module pc_stack_unit #(
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       STEP       = 1,
    parameter int unsigned       DEPTH      = 4,
    parameter bit                WRAP       = 1'b1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    pc_stack_unit_if.slave    bus,
    output wire  [ADDR_W-1:0] pc_out
);
    localparam int unsigned       SUM_W    = ADDR_W + 1;
    localparam int unsigned       PTR_W    = $clog2(DEPTH + 1);
    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(DEPTH);
    localparam logic [SUM_W-1:0]  STEP_X   = SUM_W'(STEP);
    localparam logic [ADDR_W-1:0] PC_MAX   = '1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              empty_q, full_q;
    logic [ADDR_W-1:0] stack_q [DEPTH];

    logic              push_en;
    logic [SUM_W-1:0]  sum_up, sum_dn;
    logic [ADDR_W-1:0] pc_up, pc_dn, top_addr;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    // Stepped successor/predecessor; the extra bit flags carry or borrow.
    always_comb begin
        sum_up = {1'b0, pc_q} + STEP_X;
        sum_dn = {1'b0, pc_q} - STEP_X;
        pc_up  = sum_up[ADDR_W-1:0];
        pc_dn  = sum_dn[ADDR_W-1:0];
        if (!WRAP && sum_up[ADDR_W]) begin
            pc_up = PC_MAX;
        end
        if (!WRAP && sum_dn[ADDR_W]) begin
            pc_dn = '0;
        end
    end

    assign wr_idx   = IDX_W'(ptr_q);
    assign rd_idx   = IDX_W'(ptr_q - PTR_W'(1));
    assign top_addr = stack_q[rd_idx];

    // Command decode in priority order: flush > ret > call > load > inc/dec.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (bus.flush_pc) begin
            pc_d  = RESET_ADDR;
            ptr_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (bus.ret) begin
            if (empty_q) begin
                unf_d = 1'b1;
            end else begin
                pc_d  = top_addr;
                ptr_d = ptr_q - PTR_W'(1);
            end
        end else if (bus.call) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                push_en = 1'b1;
                ptr_d   = ptr_q + PTR_W'(1);
                pc_d    = bus.load_addr;
            end
        end else if (bus.load) begin
            pc_d = bus.load_addr;
        end else if (bus.inc && !bus.dec) begin
            pc_d = pc_up;
        end else if (bus.dec && !bus.inc) begin
            pc_d = pc_dn;
        end
    end

    // PC, pointer, occupancy flags and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_ADDR;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            empty_q <= (ptr_d == '0);
            full_q  <= (ptr_d == PTR_FULL);
        end
    end

    // Return-address storage; contents are meaningless above the pointer.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_q[wr_idx] <= pc_up;
        end
    end

    assign bus.pc_value    = pc_q;
    assign bus.stack_empty = empty_q;
    assign bus.stack_full  = full_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
    assign pc_out          = bus.pc_out_en ? pc_q : {ADDR_W{1'bz}};
endmodule

// File: tb/tb_pc_stack_unit.sv
// Three instances (wrap/step1/depth4, saturate/step1/depth4, wrap/step2/depth3)
// share one command stream; a scoreboard queue feeds a monitor process.
module tb_pc_stack_unit;
    localparam int unsigned AW   = 12;
    localparam int          NDUT = 3;

    logic          clock;
    logic          reset;
    logic          flush_pc, inc, dec, load, call, ret, pc_out_en;
    logic [AW-1:0] load_addr;
    wire  [AW-1:0] pc_out0, pc_out1, pc_out2;

    logic [AW-1:0] act_pc    [NDUT];
    logic [AW-1:0] act_out   [NDUT];
    logic          act_empty [NDUT];
    logic          act_full  [NDUT];
    logic          act_ovf   [NDUT];
    logic          act_unf   [NDUT];

    pc_stack_unit_if #(.ADDR_W(AW)) bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_conn
        assign bus[g].flush_pc  = flush_pc;
        assign bus[g].inc       = inc;
        assign bus[g].dec       = dec;
        assign bus[g].load      = load;
        assign bus[g].call      = call;
        assign bus[g].ret       = ret;
        assign bus[g].load_addr = load_addr;
        assign bus[g].pc_out_en = pc_out_en;
        assign act_pc[g]        = bus[g].pc_value;
        assign act_empty[g]     = bus[g].stack_empty;
        assign act_full[g]      = bus[g].stack_full;
        assign act_ovf[g]       = bus[g].overflow;
        assign act_unf[g]       = bus[g].underflow;
    end
    assign act_out[0] = pc_out0;
    assign act_out[1] = pc_out1;
    assign act_out[2] = pc_out2;

    pc_stack_unit #(.ADDR_W(AW), .STEP(1), .DEPTH(4), .WRAP(1'b1), .RESET_ADDR(12'h000))
        u_dut0 (.clock(clock), .reset(reset), .bus(bus[0]), .pc_out(pc_out0));
    pc_stack_unit #(.ADDR_W(AW), .STEP(1), .DEPTH(4), .WRAP(1'b0), .RESET_ADDR(12'h000))
        u_dut1 (.clock(clock), .reset(reset), .bus(bus[1]), .pc_out(pc_out1));
    pc_stack_unit #(.ADDR_W(AW), .STEP(2), .DEPTH(3), .WRAP(1'b1), .RESET_ADDR(12'h000))
        u_dut2 (.clock(clock), .reset(reset), .bus(bus[2]), .pc_out(pc_out2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: per-instance configuration and architectural state.
    int step_m  [NDUT] = '{1, 1, 2};
    bit wrap_m  [NDUT] = '{1'b1, 1'b0, 1'b1};
    int depth_m [NDUT] = '{4, 4, 3};
    int pc_m    [NDUT];
    int sp_m    [NDUT];
    int stk_m   [NDUT][8];
    bit ovf_m   [NDUT];
    bit unf_m   [NDUT];

    typedef struct {
        int d;
        int pc;
        bit empty;
        bit full;
        bit ovf;
        bit unf;
        bit en;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic int next_up(input int d, input int pc);
        int s = pc + step_m[d];
        if (s > 4095) s = wrap_m[d] ? s - 4096 : 4095;
        return s;
    endfunction

    function automatic int next_dn(input int d, input int pc);
        int s = pc - step_m[d];
        if (s < 0) s = wrap_m[d] ? s + 4096 : 0;
        return s;
    endfunction

    task automatic check(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[dut%0d] @%0t: got 0x%0h, expected 0x%0h", name, d, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            pc_m[d]  = 0;
            sp_m[d]  = 0;
            ovf_m[d] = 1'b0;
            unf_m[d] = 1'b0;
        end
    endtask

    // Apply the current command inputs to the model, then queue expectations.
    task automatic model_cycle();
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (flush_pc) begin
                pc_m[d] = 0; sp_m[d] = 0; ovf_m[d] = 1'b0; unf_m[d] = 1'b0;
            end else if (ret) begin
                if (sp_m[d] == 0) unf_m[d] = 1'b1;
                else begin
                    sp_m[d]--;
                    pc_m[d] = stk_m[d][sp_m[d]];
                end
            end else if (call) begin
                if (sp_m[d] == depth_m[d]) ovf_m[d] = 1'b1;
                else begin
                    stk_m[d][sp_m[d]] = next_up(d, pc_m[d]);
                    sp_m[d]++;
                    pc_m[d] = int'(load_addr);
                end
            end else if (load) begin
                pc_m[d] = int'(load_addr);
            end else if (inc && !dec) begin
                pc_m[d] = next_up(d, pc_m[d]);
            end else if (dec && !inc) begin
                pc_m[d] = next_dn(d, pc_m[d]);
            end
            e.d     = d;
            e.pc    = pc_m[d];
            e.empty = (sp_m[d] == 0);
            e.full  = (sp_m[d] == depth_m[d]);
            e.ovf   = ovf_m[d];
            e.unf   = unf_m[d];
            e.en    = pc_out_en;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_cycle(input bit fl, input bit i, input bit dc, input bit ld,
                            input bit cl, input bit rt, input int addr, input bit en);
        @(negedge clock);
        flush_pc  = fl;
        inc       = i;
        dec       = dc;
        load      = ld;
        call      = cl;
        ret       = rt;
        load_addr = AW'(addr);
        pc_out_en = en;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset values, sampled with no clock edge in between.
    task automatic check_reset();
        for (int d = 0; d < NDUT; d++) begin
            check("rst_pc",    d, int'(act_pc[d]), 0);
            check("rst_empty", d, int'(act_empty[d]), 1);
            check("rst_full",  d, int'(act_full[d]), 0);
            check("rst_ovf",   d, int'(act_ovf[d]), 0);
            check("rst_unf",   d, int'(act_unf[d]), 0);
        end
    endtask

    // Monitor: after each active edge, compare every queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_value", e.d, int'(act_pc[e.d]), e.pc);
                check("empty",    e.d, int'(act_empty[e.d]), int'(e.empty));
                check("full",     e.d, int'(act_full[e.d]), int'(e.full));
                check("overflow", e.d, int'(act_ovf[e.d]), int'(e.ovf));
                check("underflow",e.d, int'(act_unf[e.d]), int'(e.unf));
                if (e.en) begin
                    check("pc_out", e.d, int'(act_out[e.d]), e.pc);
                end else if (e.pc != 0) begin
                    checks++;
                    if (act_out[e.d] === AW'(e.pc)) begin
                        errors++;
                        $display("FAIL pc_out_hiz[dut%0d] @%0t: got 0x%0h, expected high-Z",
                                 e.d, $time, act_out[e.d]);
                    end
                end
            end
        end
    end

    initial begin
        int r;
        bit fl, i, dc, ld, cl, rt, en;
        int addr;

        reset = 1'b1;
        flush_pc = 0; inc = 0; dec = 0; load = 0; call = 0; ret = 0;
        load_addr = '0; pc_out_en = 0;
        model_reset();
        #2;
        check_reset();
        @(negedge clock);
        reset = 1'b0;

        // Count up, then reset asynchronously mid-count.
        for (int k = 0; k < 5; k++) do_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        inc = 0;
        #1;
        check_reset();
        model_reset();
        @(negedge clock);
        reset = 1'b0;

        // Top and bottom boundaries.
        do_cycle(0, 0, 0, 1, 0, 0, 12'hFFF, 0);
        do_cycle(0, 1, 0, 0, 0, 0, 0, 1);
        do_cycle(0, 0, 0, 1, 0, 0, 12'h000, 0);
        do_cycle(0, 0, 1, 0, 0, 0, 0, 1);

        // Call, run in the subroutine, return.
        do_cycle(0, 0, 0, 1, 0, 0, 12'h010, 0);
        do_cycle(0, 0, 0, 0, 1, 0, 12'h200, 0);
        for (int k = 0; k < 3; k++) do_cycle(0, 1, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 1, 0, 1);

        // Fill past capacity, then drain past empty.
        do_cycle(0, 0, 0, 1, 0, 0, 12'h000, 0);
        for (int k = 0; k < 5; k++) do_cycle(0, 0, 0, 0, 1, 0, 12'h100 + k, 0);
        for (int k = 0; k < 5; k++) do_cycle(0, 0, 0, 0, 0, 1, 0, 1);

        // Same-cycle conflicts.
        do_cycle(0, 0, 0, 0, 1, 0, 12'h300, 0);
        do_cycle(1, 1, 0, 0, 1, 0, 12'h400, 0);
        do_cycle(0, 0, 0, 1, 0, 0, 12'h050, 0);
        do_cycle(0, 0, 0, 0, 1, 0, 12'h500, 0);
        do_cycle(0, 0, 0, 1, 0, 1, 12'h777, 0);
        do_cycle(0, 1, 1, 0, 0, 0, 0, 1);

        // Bus enable toggles while counting up from zero.
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) do_cycle(0, 1, 0, 0, 0, 0, 0, k[0]);

        // Randomized command mix, biased toward the address extremes.
        for (int k = 0; k < 400; k++) begin
            r    = int'($urandom_range(0, 99));
            fl   = (r < 3);
            rt   = ($urandom_range(0, 5) == 0);
            cl   = ($urandom_range(0, 4) == 0);
            ld   = ($urandom_range(0, 6) == 0);
            i    = ($urandom_range(0, 1) == 1);
            dc   = ($urandom_range(0, 2) == 0);
            en   = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 2))
                0:       addr = 4095 - int'($urandom_range(0, 3));
                1:       addr = int'($urandom_range(0, 3));
                default: addr = int'($urandom_range(0, 4095));
            endcase
            do_cycle(fl, i, dc, ld, cl, rt, addr, en);
        end
        idle(2);

        @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
